// File: rtl/uart_tx_fifo_if.sv
// Host write port and transmitter launch handshake of uart_tx_fifo.
interface uart_tx_fifo_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              send;
  logic [7:0]        dintx;
  logic              donetx;
  logic              busy;

  // Host / transmitter side.
  modport master (
    output wr_en, wr_data, donetx,
    input  full, empty, count, overflow, send, dintx, busy
  );

  // FIFO side.
  modport slave (
    input  wr_en, wr_data, donetx,
    output full, empty, count, overflow, send, dintx, busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: stores host bytes and launches them one at a time,
// retiring each byte on the rising edge of the transmitter's donetx completion level.
module uart_tx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);

  localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne   = ADDR_W'(1);

  typedef enum logic [1:0] {StIdle, StSend, StDrain} state_e;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q;
  logic              done_q;
  logic              done_rise;
  logic              pop;
  logic              wr_accept;
  logic              full, empty;
  state_e            state_q, state_d;
  logic              send_q, send_d;
  logic [7:0]        dintx_q, dintx_d;

  assign full      = (count_q == DepthCnt);
  assign empty     = (count_q == '0);
  assign done_rise = bus.donetx & ~done_q;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write then.
  assign wr_accept = bus.wr_en & (~full | pop);

  // Launch sequencer: next state, launch request and popped-byte decision.
  always_comb begin
    state_d = state_q;
    send_d  = send_q;
    dintx_d = dintx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        send_d = 1'b0;
        if (!empty) begin
          dintx_d = mem_q[rd_ptr_q];
          send_d  = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        if (done_rise) begin
          pop     = 1'b1;
          send_d  = 1'b0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        send_d = 1'b0;
        // Wait out the completion level so the same done is never seen twice.
        if (!bus.donetx) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Occupancy: write and pop in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    if (wr_accept && !pop)      count_d = count_q + CntOne;
    else if (pop && !wr_accept) count_d = count_q - CntOne;
  end

  // Control state, pointers and registered transmitter outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      state_q    <= StIdle;
      send_q     <= 1'b0;
      dintx_q    <= 8'h00;
    end else begin
      if (wr_accept) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)       rd_ptr_q <= rd_ptr_q + PtrOne;
      count_q <= count_d;
      if (bus.wr_en && !wr_accept) overflow_q <= 1'b1;
      done_q  <= bus.donetx;
      state_q <= state_d;
      send_q  <= send_d;
      dintx_q <= dintx_d;
    end
  end

  // Byte storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.send     = send_q;
  assign bus.dintx    = dintx_q;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised self-checking bench for uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CW     = ADDR_W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model and observation state.
  logic [7:0] model_q [$];   // bytes the FIFO should hold, front = oldest
  logic [7:0] acc_log [$];   // every accepted byte, in order
  logic [7:0] tx_log  [$];   // every byte launched by the DUT
  bit         m_over;
  bit         frame_open;    // a launch has been seen and not yet completed
  bit         dt_prev;
  bit         prev_send;
  logic [7:0] held;
  int         unstable;
  int         n_vec  = 0;
  int         n_fail = 0;

  // One clock of stimulus; the model advances with the same edge.
  task automatic cycle(input bit we, input logic [7:0] wd, input bit dt);
    bit rise;
    int sz;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.donetx  = dt;
    @(posedge clk);
    rise = dt && !dt_prev && frame_open;
    sz   = model_q.size();
    if (rise) begin
      void'(model_q.pop_front());
      frame_open = 1'b0;
    end
    if (we) begin
      if (sz < DEPTH || rise) begin
        model_q.push_back(wd);
        acc_log.push_back(wd);
      end else begin
        m_over = 1'b1;
      end
    end
    dt_prev = dt;
    #1;
    if (bus.send && !prev_send) begin
      tx_log.push_back(bus.dintx);
      frame_open = 1'b1;
    end else if (bus.send && bus.dintx !== held) begin
      unstable++;
    end
    held      = bus.dintx;
    prev_send = bus.send;
  endtask

  task automatic do_reset(input bit we);
    rst         = 1'b1;
    bus.wr_en   = we;
    bus.wr_data = 8'hFF;
    bus.donetx  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    acc_log.delete();
    tx_log.delete();
    m_over     = 1'b0;
    frame_open = 1'b0;
    dt_prev    = 1'b0;
    prev_send  = 1'b0;
    held       = 8'h00;
    unstable   = 0;
  endtask

  // Transmitter model: completes every launch after a random stall and pulse width.
  task automatic drain_all(input int budget);
    int t = 0;
    while ((model_q.size() > 0 || frame_open) && t < budget) begin
      if (frame_open) begin
        repeat ($urandom_range(0, 5)) cycle(1'b0, 8'h00, 1'b0);
        repeat ($urandom_range(1, 3)) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
      end else begin
        cycle(1'b0, 8'h00, 1'b0);
      end
      t++;
    end
    repeat (4) cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset;
    do_reset(1'b1);
    n_vec += 7;
    if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL rst_count got %0d want 0", bus.count); end
    if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b want 1", bus.empty); end
    if (bus.full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b want 0", bus.full); end
    if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b want 0", bus.overflow); end
    if (bus.send !== 1'b0) begin n_fail++; $display("FAIL rst_send got %b want 0", bus.send); end
    if (bus.dintx !== 8'h00) begin n_fail++; $display("FAIL rst_dintx got %h want 00", bus.dintx); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_single;
    do_reset(1'b0);
    cycle(1'b1, 8'hA5, 1'b0);
    n_vec += 2;
    if (bus.count !== CW'(1)) begin n_fail++; $display("FAIL single_cnt got %0d want 1", bus.count); end
    if (bus.send !== 1'b0) begin n_fail++; $display("FAIL single_early got %b want 0", bus.send); end
    cycle(1'b0, 8'h00, 1'b0);
    n_vec += 3;
    if (bus.send !== 1'b1) begin n_fail++; $display("FAIL single_send got %b want 1", bus.send); end
    if (bus.dintx !== 8'hA5) begin n_fail++; $display("FAIL single_dintx got %h want a5", bus.dintx); end
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", bus.busy); end
    repeat (200) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    n_vec += 3;
    if (bus.send !== 1'b0) begin n_fail++; $display("FAIL single_drop got %b want 0", bus.send); end
    if (bus.count !== CW'(model_q.size())) begin
      n_fail++; $display("FAIL single_pop got %0d want %0d", bus.count, model_q.size());
    end
    if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL single_empty got %b want 1", bus.empty); end
    repeat (5) cycle(1'b0, 8'h00, 1'b0);
    n_vec += 2;
    if (tx_log.size() !== 1) begin n_fail++; $display("FAIL single_frames got %0d want 1", tx_log.size()); end
    else if (tx_log[0] !== 8'hA5) begin n_fail++; $display("FAIL single_byte got %h want a5", tx_log[0]); end
    if (unstable !== 0) begin n_fail++; $display("FAIL single_stable got %0d want 0", unstable); end
  endtask

  // Compares launched bytes with accepted bytes after a full drain.
  task automatic test_order(input string name);
    n_vec += 2;
    if (tx_log.size() !== acc_log.size()) begin
      n_fail++; $display("FAIL %s_frames got %0d want %0d", name, tx_log.size(), acc_log.size());
    end else begin
      for (int i = 0; i < tx_log.size(); i++) begin
        n_vec++;
        if (tx_log[i] !== acc_log[i]) begin
          n_fail++; $display("FAIL %s_byte%0d got %h want %h", name, i, tx_log[i], acc_log[i]);
        end
      end
    end
    if (unstable !== 0) begin n_fail++; $display("FAIL %s_stable got %0d want 0", name, unstable); end
  endtask

  task automatic test_burst;
    do_reset(1'b0);
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i), 1'b0);
    n_vec++;
    if (bus.count !== CW'(5)) begin n_fail++; $display("FAIL burst_cnt got %0d want 5", bus.count); end
    drain_all(200);
    n_vec++;
    if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL burst_end got %0d want 0", bus.count); end
    n_vec++;
    if (acc_log.size() !== 5) begin n_fail++; $display("FAIL burst_acc got %0d want 5", acc_log.size()); end
    test_order("burst");
  endtask

  task automatic test_overflow;
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0);
    n_vec += 2;
    if (bus.full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", bus.full); end
    if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", bus.overflow); end
    cycle(1'b1, 8'h20, 1'b0);
    n_vec += 2;
    if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", bus.overflow); end
    if (bus.count !== CW'(16)) begin n_fail++; $display("FAIL ovf_cnt got %0d want 16", bus.count); end
    drain_all(400);
    test_order("ovf");
    n_vec += 2;
    if (tx_log.size() > 0 && tx_log[tx_log.size()-1] !== 8'h1F) begin
      n_fail++; $display("FAIL ovf_last got %h want 1f", tx_log[tx_log.size()-1]);
    end
    if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
    // Pointers have wrapped; new bytes must still come out in order.
    cycle(1'b1, 8'hE1, 1'b0);
    cycle(1'b1, 8'hE2, 1'b0);
    drain_all(100);
    test_order("wrap");
  endtask

  task automatic test_full_pop;
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom), 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h77, 1'b1);
    n_vec += 3;
    if (bus.count !== CW'(16)) begin n_fail++; $display("FAIL fullpop_cnt got %0d want 16", bus.count); end
    if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf got %b want 0", bus.overflow); end
    if (bus.full !== 1'b1) begin n_fail++; $display("FAIL fullpop_full got %b want 1", bus.full); end
    drain_all(400);
    n_vec++;
    if (tx_log.size() !== 17 || tx_log[16] !== 8'h77) begin
      n_fail++; $display("FAIL fullpop_last got %0d frames want 17 ending 77", tx_log.size());
    end
    test_order("fullpop");
  endtask

  task automatic test_reset_mid;
    do_reset(1'b0);
    cycle(1'b1, 8'hC1, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0);
    n_vec += 2;
    if (bus.send !== 1'b1) begin n_fail++; $display("FAIL mid_pre_send got %b want 1", bus.send); end
    if (bus.count !== CW'(3)) begin n_fail++; $display("FAIL mid_pre_cnt got %0d want 3", bus.count); end
    do_reset(1'b0);
    n_vec += 4;
    if (bus.send !== 1'b0) begin n_fail++; $display("FAIL mid_send got %b want 0", bus.send); end
    if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL mid_cnt got %0d want 0", bus.count); end
    if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty got %b want 1", bus.empty); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", bus.busy); end
    repeat (20) cycle(1'b0, 8'h00, 1'b0);
    n_vec += 2;
    if (tx_log.size() !== 0) begin n_fail++; $display("FAIL mid_quiet got %0d want 0", tx_log.size()); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle got %b want 0", bus.busy); end
    cycle(1'b1, 8'h5A, 1'b0);
    drain_all(100);
    test_order("mid");
  endtask

  task automatic test_done_idle;
    do_reset(1'b0);
    repeat (5) cycle(1'b0, 8'h00, 1'b1);
    n_vec += 2;
    if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL idle_cnt got %0d want 0", bus.count); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", bus.busy); end
    cycle(1'b1, 8'h3C, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);
    n_vec += 2;
    if (bus.count !== CW'(1)) begin n_fail++; $display("FAIL idle_nopop got %0d want 1", bus.count); end
    if (bus.send !== 1'b1) begin n_fail++; $display("FAIL idle_send got %b want 1", bus.send); end
    cycle(1'b0, 8'h00, 1'b0);
    drain_all(100);
    n_vec++;
    if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL idle_end got %0d want 0", bus.count); end
    test_order("idle");
  endtask

  task automatic test_random;
    int  wait_c = -1;
    int  hold_c = 0;
    bit  we;
    bit  dt;
    do_reset(1'b0);
    for (int i = 0; i < 1500; i++) begin
      we = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      if (hold_c > 0) begin
        dt = 1'b1;
        hold_c--;
      end else if (frame_open) begin
        if (wait_c < 0) wait_c = int'($urandom_range(0, 6));
        if (wait_c == 0) begin
          dt     = 1'b1;
          hold_c = int'($urandom_range(0, 2));
          wait_c = -1;
        end else begin
          dt = 1'b0;
          wait_c--;
        end
      end else begin
        dt = 1'b0;
      end
      cycle(we, 8'($urandom), dt);
      n_vec += 4;
      if (bus.count !== CW'(model_q.size())) begin
        n_fail++; $display("FAIL rnd_cnt@%0d got %0d want %0d", i, bus.count, model_q.size());
      end
      if (bus.full !== (model_q.size() == DEPTH)) begin
        n_fail++; $display("FAIL rnd_full@%0d got %b want %b", i, bus.full, model_q.size() == DEPTH);
      end
      if (bus.empty !== (model_q.size() == 0)) begin
        n_fail++; $display("FAIL rnd_empty@%0d got %b want %b", i, bus.empty, model_q.size() == 0);
      end
      if (bus.overflow !== m_over) begin
        n_fail++; $display("FAIL rnd_ovf@%0d got %b want %b", i, bus.overflow, m_over);
      end
    end
    repeat (4) cycle(1'b0, 8'h00, 1'b0);
    drain_all(400);
    test_order("rnd");
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.donetx  = 1'b0;
    test_reset;
    test_single;
    test_burst;
    test_overflow;
    test_full_pop;
    test_reset_mid;
    test_done_idle;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired after %0d vectors", n_vec);
    $fatal(1, "timeout");
  end

endmodule
